// File: rtl/inv_lane_sequencer_if.sv
// Wishbone slave bundle for the inverter lane sequencer.
// Signal names are the Caravel user-project names, seen from the slave:
//   wbs_stb_i, wbs_cyc_i, wbs_we_i : strobe, cycle, write enable
//   wbs_sel_i                      : byte enables for writes
//   wbs_adr_i, wbs_dat_i           : address and write data
//   wbs_ack_o, wbs_dat_o           : acknowledge and read data
interface inv_lane_sequencer_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/inv_lane_sequencer.sv
// Test sequencer for the user-area inverter lanes. Drives a counting pattern
// onto the lane pads, holds each value for PERIOD cycles, samples the inverted
// return at the end of each step and counts steps with any mismatching lane.
//
// Ports:
//   wb_clk_i  : the only clock, rising edge
//   wb_rst_i  : synchronous active-high reset
//   wbs       : Wishbone slave (register file, see map below)
//   pad_in    : returned lane values (expected to be the inverse of pad_out)
//   pad_out   : driven lane values, 0 while idle
//   pad_oeb   : active-low output enables, all ones while idle
//   irq       : level interrupt, DONE & IRQ_EN
//
// Register map (word offset adr[4:2]):
//   0x00 CTRL    W:START(0) ABORT(1) CLR_DONE(3)  RW:IRQ_EN(2)  R:BUSY(8) DONE(9)
//   0x04 PERIOD  cycles per step, 0 behaves as 1
//   0x08 SEED    first pattern
//   0x0C STEPS   number of steps, 0 means 256
//   0x10 ENABLE  lane mask
//   0x14 ERRCNT  saturating mismatch count (RO)
//   0x18 CAPTURE last sampled pad_in (RO)
//   0x1C and up  read 0, writes ignored
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | pads released, configuration writable, waiting for START
// RUN   | pads driven, stepping the pattern, config and IRQ_EN locked
module inv_lane_sequencer #(
    parameter int          LANES    = 8,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    inv_lane_sequencer_if.slave wbs,
    input  logic [LANES-1:0]  pad_in,
    output logic [LANES-1:0]  pad_out,
    output logic [LANES-1:0]  pad_oeb,
    output logic              irq
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic              ack_q;
    logic [31:0]       dat_q;
    logic [15:0]       period_q;
    logic [LANES-1:0]  seed_q;
    logic [7:0]        steps_q;
    logic [LANES-1:0]  enable_q;
    logic              irq_en_q;
    logic              done_q;
    logic [15:0]       errcnt_q;
    logic [LANES-1:0]  capture_q;
    logic [LANES-1:0]  pattern_q;
    logic [7:0]        step_cnt_q;
    logic [15:0]       cyc_cnt_q;

    logic        busy;
    logic        decode;
    logic        accept;
    logic        wr;
    logic        in_map;
    logic [2:0]  idx;
    logic        wr_cfg;
    logic        ctrl_wr;
    logic [31:0] bmask;
    logic [31:0] rdata;
    logic [15:0] reload;
    logic        mismatch;

    logic start_run;
    logic abort_run;
    logic step_end;
    logic run_done;

    assign busy   = (state_q == S_RUN);
    assign decode = (wbs.wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign accept = wbs.wbs_stb_i & wbs.wbs_cyc_i & decode & ~ack_q;
    assign wr     = accept & wbs.wbs_we_i;

    // Anything at or above 0x1C inside the 256-byte window is a hole.
    assign in_map = (wbs.wbs_adr_i[7:2] < 6'd7);
    assign idx    = wbs.wbs_adr_i[4:2];

    // Config registers and IRQ_EN are frozen for the whole run.
    assign wr_cfg  = wr & in_map & ~busy;
    assign ctrl_wr = wr & in_map & (idx == 3'd0) & wbs.wbs_sel_i[0];

    assign bmask = {{8{wbs.wbs_sel_i[3]}}, {8{wbs.wbs_sel_i[2]}},
                    {8{wbs.wbs_sel_i[1]}}, {8{wbs.wbs_sel_i[0]}}};

    assign reload   = (period_q == 16'd0) ? 16'd0 : period_q - 16'd1;
    assign mismatch = |((pad_in ^ ~pattern_q) & enable_q);

    logic unused_ok;
    assign unused_ok = ^{wbs.wbs_adr_i[1:0], bmask[31:16], wbs.wbs_dat_i[31:16]};

    always_comb begin
        state_d   = state_q;
        start_run = 1'b0;
        abort_run = 1'b0;
        step_end  = 1'b0;
        run_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // ABORT in the same write suppresses START.
                if (ctrl_wr && wbs.wbs_dat_i[0] && !wbs.wbs_dat_i[1]) begin
                    start_run = 1'b1;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                // ABORT beats a coinciding step end: no sample is taken.
                if (ctrl_wr && wbs.wbs_dat_i[1]) begin
                    abort_run = 1'b1;
                    state_d   = S_IDLE;
                end else if (cyc_cnt_q == 16'd0) begin
                    step_end = 1'b1;
                    // Step counter starting at 0 wraps through 255, giving 256 steps.
                    if (step_cnt_q == 8'd1) begin
                        run_done = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdata = 32'd0;
        if (in_map) begin
            case (idx)
                3'd0: rdata = {22'd0, done_q, busy, 5'd0, irq_en_q, 2'd0};
                3'd1: rdata = {16'd0, period_q};
                3'd2: rdata = {{(32-LANES){1'b0}}, seed_q};
                3'd3: rdata = {24'd0, steps_q};
                3'd4: rdata = {{(32-LANES){1'b0}}, enable_q};
                3'd5: rdata = {16'd0, errcnt_q};
                3'd6: rdata = {{(32-LANES){1'b0}}, capture_q};
                default: rdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            ack_q      <= 1'b0;
            dat_q      <= 32'd0;
            period_q   <= 16'd1;
            seed_q     <= '0;
            steps_q    <= 8'd0;
            enable_q   <= '0;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            errcnt_q   <= 16'd0;
            capture_q  <= '0;
            pattern_q  <= '0;
            step_cnt_q <= 8'd0;
            cyc_cnt_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            ack_q   <= accept;
            // Read data is presented only alongside ack.
            dat_q   <= (accept && !wbs.wbs_we_i) ? rdata : 32'd0;

            if (wr_cfg) begin
                case (idx)
                    3'd0: if (wbs.wbs_sel_i[0]) irq_en_q <= wbs.wbs_dat_i[2];
                    3'd1: period_q <= (period_q & ~bmask[15:0]) |
                                      (wbs.wbs_dat_i[15:0] & bmask[15:0]);
                    3'd2: seed_q   <= (seed_q & ~bmask[LANES-1:0]) |
                                      (wbs.wbs_dat_i[LANES-1:0] & bmask[LANES-1:0]);
                    3'd3: if (wbs.wbs_sel_i[0]) steps_q <= wbs.wbs_dat_i[7:0];
                    3'd4: enable_q <= (enable_q & ~bmask[LANES-1:0]) |
                                      (wbs.wbs_dat_i[LANES-1:0] & bmask[LANES-1:0]);
                    default: ;
                endcase
            end

            if (ctrl_wr && wbs.wbs_dat_i[3]) begin
                done_q <= 1'b0;
            end

            if (start_run) begin
                pattern_q  <= seed_q;
                step_cnt_q <= steps_q;
                cyc_cnt_q  <= reload;
                errcnt_q   <= 16'd0;
                done_q     <= 1'b0;
            end else if (busy && !abort_run) begin
                if (step_end) begin
                    capture_q <= pad_in;
                    if (mismatch && errcnt_q != 16'hFFFF) begin
                        errcnt_q <= errcnt_q + 16'd1;
                    end
                    if (run_done) begin
                        done_q <= 1'b1;
                    end else begin
                        pattern_q  <= pattern_q + LANES'(1);
                        cyc_cnt_q  <= reload;
                        step_cnt_q <= step_cnt_q - 8'd1;
                    end
                end else begin
                    cyc_cnt_q <= cyc_cnt_q - 16'd1;
                end
            end
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;

    always_comb begin
        pad_out = '0;
        pad_oeb = '1;
        if (busy) begin
            pad_out = pattern_q & enable_q;
            pad_oeb = ~enable_q;
        end
    end

    assign irq = done_q & irq_en_q;

endmodule

// File: tb/tb_inv_lane_sequencer.sv
module tb_inv_lane_sequencer;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pad_in, pad_out, pad_oeb, stuck;
    logic       irq;
    logic       cur_we = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [15:0] pad_q[$];

    always #5 clk = ~clk;

    inv_lane_sequencer_if wb();

    // Loopback through the inverters, with optional lanes stuck at 0.
    assign pad_in = ~pad_out & ~stuck;

    inv_lane_sequencer #(.LANES(8), .BASE_ADR(BASE)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs      (wb),
        .pad_in   (pad_in),
        .pad_out  (pad_out),
        .pad_oeb  (pad_oeb),
        .irq      (irq)
    );

    // Monitor: read responses on ack, pad values whenever any lane is driven.
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        logic [15:0] p;
        string       n;
        if (!rst && wb.wbs_ack_o && !cur_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read got=%h", wb.wbs_dat_o);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (wb.wbs_dat_o !== e) begin
                    errors++;
                    $display("FAIL %s got=%h exp=%h", n, wb.wbs_dat_o, e);
                end
            end
        end
        if (!rst && pad_oeb !== 8'hFF) begin
            checks++;
            if (pad_q.size() == 0) begin
                errors++;
                $display("FAIL pad_extra out=%h oeb=%h", pad_out, pad_oeb);
            end else begin
                p = pad_q.pop_front();
                if ({pad_out, pad_oeb} !== p) begin
                    errors++;
                    $display("FAIL pad_seq out=%h oeb=%h exp_out=%h exp_oeb=%h",
                             pad_out, pad_oeb, p[15:8], p[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
        int n;
        @(negedge clk);
        cur_we        = we;
        wb.wbs_stb_i  = 1'b1;
        wb.wbs_cyc_i  = 1'b1;
        wb.wbs_we_i   = we;
        wb.wbs_adr_i  = adr;
        wb.wbs_dat_i  = dat;
        wb.wbs_sel_i  = sel;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wb.wbs_ack_o && n < 8);
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        if (!wb.wbs_ack_o) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout adr=%h got=no_ack exp=ack", adr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] dat);
        wb_xfer(1'b1, BASE + {24'd0, off}, dat, 4'hF);
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        wb_xfer(1'b0, BASE + {24'd0, off}, 32'd0, 4'hF);
    endtask

    task automatic push_run(input logic [7:0] seed, input int steps, input int period,
                            input logic [7:0] en);
        logic [7:0] pat;
        int per;
        per = (period == 0) ? 1 : period;
        pat = seed;
        for (int s = 0; s < steps; s++) begin
            for (int c = 0; c < per; c++) pad_q.push_back({pat & en, ~en});
            pat = pat + 8'd1;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (pad_oeb !== 8'hFF && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_timeout"}, {31'd0, pad_oeb === 8'hFF}, 32'd1);
        check({name, "_pad_missing"}, pad_q.size(), 32'd0);
    endtask

    task automatic setup_run(input logic [7:0] en, input logic [7:0] seed,
                             input logic [7:0] steps, input logic [15:0] period);
        wr(8'h10, {24'd0, en});
        wr(8'h08, {24'd0, seed});
        wr(8'h0C, {24'd0, steps});
        wr(8'h04, {16'd0, period});
    endtask

    initial begin
        bit seen;
        int n;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'h0;
        wb.wbs_adr_i = 32'd0;
        wb.wbs_dat_i = 32'd0;
        stuck        = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_pad_oeb", {24'd0, pad_oeb}, 32'hFF);
        check("rst_pad_out", {24'd0, pad_out}, 32'h00);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_ack", {31'd0, wb.wbs_ack_o}, 32'd0);
        check("rst_dat", wb.wbs_dat_o, 32'd0);
        rd(8'h04, 32'h1, "rst_period");
        rd(8'h00, 32'h0, "rst_ctrl");

        // Byte lane 1 only: low byte of PERIOD keeps its reset value.
        wb_xfer(1'b1, BASE + 32'h4, 32'h0000_ABCD, 4'b0010);
        rd(8'h04, 32'hAB01, "period_bytesel");
        wr(8'h1C, 32'hFFFF_FFFF);
        rd(8'h1C, 32'h0, "hole_read");

        // Outside the window: must never be acked.
        @(negedge clk);
        wb.wbs_stb_i = 1'b1;
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_we_i  = 1'b1;
        wb.wbs_adr_i = 32'h4000_0004;
        wb.wbs_sel_i = 4'hF;
        cur_we       = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (wb.wbs_ack_o) seen = 1'b1;
        end
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        check("nodecode_ack", {31'd0, seen}, 32'd0);
        rd(8'h04, 32'hAB01, "nodecode_period");

        // Loopback run: 00..03, three cycles each.
        setup_run(8'hFF, 8'h00, 8'd4, 16'd3);
        wr(8'h00, 32'h4);
        push_run(8'h00, 4, 3, 8'hFF);
        wr(8'h00, 32'h5);
        wait_idle("loop");
        rd(8'h14, 32'h0, "loop_errcnt");
        rd(8'h18, 32'hFC, "loop_capture");
        rd(8'h00, 32'h204, "loop_ctrl");
        check("loop_irq", {31'd0, irq}, 32'd1);
        wr(8'h00, 32'hC);
        check("clr_irq", {31'd0, irq}, 32'd0);
        rd(8'h00, 32'h004, "clr_ctrl");

        // Lane 0 stuck low: steps 0 and 2 expect a 1 on lane 0.
        stuck = 8'h01;
        push_run(8'h00, 4, 3, 8'hFF);
        wr(8'h00, 32'h5);
        wait_idle("stuck");
        rd(8'h14, 32'h2, "stuck_errcnt");
        rd(8'h18, 32'hFC, "stuck_capture");

        // Same stuck lane, masked off.
        wr(8'h10, 32'hFE);
        push_run(8'h00, 4, 3, 8'hFE);
        wr(8'h00, 32'h5);
        wait_idle("masked");
        rd(8'h14, 32'h0, "masked_errcnt");
        rd(8'h18, 32'hFC, "masked_capture");

        // Pattern wrap with PERIOD 0.
        stuck = 8'h00;
        setup_run(8'hFF, 8'hFE, 8'd3, 16'd0);
        push_run(8'hFE, 3, 0, 8'hFF);
        wr(8'h00, 32'h5);
        wait_idle("wrap");
        rd(8'h14, 32'h0, "wrap_errcnt");
        rd(8'h04, 32'h0, "wrap_period");
        rd(8'h18, 32'hFF, "wrap_capture");

        // STEPS 0 means 256 steps.
        setup_run(8'hFF, 8'h00, 8'd0, 16'd1);
        push_run(8'h00, 256, 1, 8'hFF);
        wr(8'h00, 32'h5);
        wait_idle("steps256");
        rd(8'h00, 32'h204, "steps256_ctrl");
        rd(8'h18, 32'h00, "steps256_capture");

        // Abort: PERIOD write and second START ignored while busy.
        stuck = 8'h01;
        setup_run(8'hFF, 8'h00, 8'd4, 16'd3);
        push_run(8'h00, 2, 3, 8'hFF);
        wr(8'h00, 32'h5);
        wr(8'h04, 32'h7);
        wr(8'h00, 32'h5);
        wb_xfer(1'b1, BASE, 32'h6, 4'hF);
        check("abort_oeb", {24'd0, pad_oeb}, 32'hFF);
        check("abort_out", {24'd0, pad_out}, 32'h00);
        check("abort_pad_left", pad_q.size(), 32'd0);
        check("abort_irq", {31'd0, irq}, 32'd0);
        rd(8'h00, 32'h004, "abort_ctrl");
        rd(8'h04, 32'h3, "abort_period");
        rd(8'h14, 32'h1, "abort_errcnt");
        rd(8'h18, 32'hFE, "abort_capture");

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reads_pending", exp_q.size(), 32'd0);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
